// File: rtl/usb_protocol_ctrl.sv
// USB full-speed endpoint packet sequencer: answers tokens with handshakes, times out
// missing responses and reports transfer completion/error status to the register side.
//
// state        | meaning
// IDLE         | listening, no IN data armed
// RX_WAIT_DATA | OUT token seen, waiting for the DATA packet (timed)
// RX_DATA      | DATA handling, resolved combinationally at the DATA strobe; never registered
// SEND_HS      | driving an ACK/NAK handshake, waiting for TX to finish
// TX_ARMED     | IN data loaded, waiting for the host's IN token
// TX_DATA      | driving DATA0, waiting for TX to finish
// TX_WAIT_ACK  | DATA0 sent, waiting for the host handshake (timed)
module usb_protocol_ctrl #(
    parameter int BUF_DEPTH = 64,
    parameter int TIMEOUT   = 800
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] rx_packet,
    input  logic       rx_packet_valid,
    input  logic       rx_transfer_active,
    input  logic       rx_error,
    input  logic       tx_transfer_active,
    input  logic       tx_error,
    input  logic [6:0] buffer_occupancy,
    input  logic       host_send_req,
    input  logic       err_clear,
    output logic [2:0] tx_packet,
    output logic       tx_start,
    output logic       d_mode,
    output logic       clear_buffer,
    output logic       rx_done,
    output logic       tx_done,
    output logic       xfer_error,
    output logic       busy
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

    localparam logic [2:0] PID_OUT  = 3'd1;
    localparam logic [2:0] PID_IN   = 3'd2;
    localparam logic [2:0] PID_DATA = 3'd3;
    localparam logic [2:0] PID_ACK  = 3'd4;
    localparam logic [2:0] PID_NAK  = 3'd5;

    localparam logic [2:0] TXP_IDLE  = 3'd0;
    localparam logic [2:0] TXP_DATA0 = 3'd1;
    localparam logic [2:0] TXP_ACK   = 3'd2;
    localparam logic [2:0] TXP_NAK   = 3'd3;

    typedef enum logic [2:0] {
        IDLE,
        RX_WAIT_DATA,
        RX_DATA,
        SEND_HS,
        TX_ARMED,
        TX_DATA,
        TX_WAIT_ACK
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt, timer_inc;
    logic          seen, seen_nxt;
    logic          ret_armed, ret_armed_nxt;
    logic          hs_ack, hs_ack_nxt;
    logic [2:0]    tx_packet_nxt;
    logic          tx_start_nxt, d_mode_nxt, clear_nxt;
    logic          rx_done_nxt, tx_done_nxt, set_err;
    logic          pkt_valid, pkt_known, timeout;
    logic          pkt_out, pkt_in, pkt_data, pkt_ack;

    // The RX side is not listened to while we own the bus.
    assign pkt_valid = rx_packet_valid && !d_mode;
    assign pkt_known = pkt_valid && (rx_packet >= PID_OUT) && (rx_packet <= PID_NAK);
    assign pkt_out   = pkt_valid && (rx_packet == PID_OUT);
    assign pkt_in    = pkt_valid && (rx_packet == PID_IN);
    assign pkt_data  = pkt_valid && (rx_packet == PID_DATA);
    assign pkt_ack   = pkt_valid && (rx_packet == PID_ACK);

    // A packet already being received at the deadline gets to finish; the timer saturates meanwhile.
    assign timeout   = (timer == TIMER_MAX) && !rx_transfer_active;
    assign timer_inc = (timer == TIMER_MAX) ? timer : timer + TW'(1);

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        seen_nxt      = seen;
        ret_armed_nxt = ret_armed;
        hs_ack_nxt    = hs_ack;
        tx_packet_nxt = tx_packet;
        tx_start_nxt  = 1'b0;
        d_mode_nxt    = d_mode;
        clear_nxt     = 1'b0;
        rx_done_nxt   = 1'b0;
        tx_done_nxt   = 1'b0;
        set_err       = 1'b0;

        case (state)
            IDLE: begin
                if (pkt_out) begin
                    state_nxt     = RX_WAIT_DATA;
                    timer_nxt     = '0;
                    ret_armed_nxt = 1'b0;
                end else if (pkt_in) begin
                    state_nxt     = SEND_HS;
                    tx_packet_nxt = TXP_NAK;
                    tx_start_nxt  = 1'b1;
                    d_mode_nxt    = 1'b1;
                    seen_nxt      = 1'b0;
                    hs_ack_nxt    = 1'b0;
                    ret_armed_nxt = 1'b0;
                end else if (host_send_req) begin
                    state_nxt = TX_ARMED;
                end
            end

            RX_WAIT_DATA: begin
                if (pkt_data) begin
                    if (rx_error) begin
                        state_nxt = ret_armed ? TX_ARMED : IDLE;
                        clear_nxt = !ret_armed;
                        set_err   = 1'b1;
                    end else if (ret_armed || (buffer_occupancy <= 7'(BUF_DEPTH))) begin
                        // Armed buffer belongs to TX: OUT data is refused with NAK.
                        state_nxt     = SEND_HS;
                        tx_packet_nxt = ret_armed ? TXP_NAK : TXP_ACK;
                        tx_start_nxt  = 1'b1;
                        d_mode_nxt    = 1'b1;
                        seen_nxt      = 1'b0;
                        hs_ack_nxt    = !ret_armed;
                    end else begin
                        state_nxt = IDLE;
                        clear_nxt = 1'b1;
                        set_err   = 1'b1;
                    end
                end else if (pkt_known || timeout) begin
                    state_nxt = ret_armed ? TX_ARMED : IDLE;
                    set_err   = 1'b1;
                end else begin
                    timer_nxt = timer_inc;
                end
            end

            SEND_HS: begin
                if (tx_transfer_active) seen_nxt = 1'b1;
                if (seen && !tx_transfer_active) begin
                    state_nxt     = ret_armed ? TX_ARMED : IDLE;
                    d_mode_nxt    = 1'b0;
                    tx_packet_nxt = TXP_IDLE;
                    rx_done_nxt   = hs_ack;
                    hs_ack_nxt    = 1'b0;
                    seen_nxt      = 1'b0;
                end
            end

            TX_ARMED: begin
                if (pkt_in) begin
                    state_nxt     = (buffer_occupancy != '0) ? TX_DATA : SEND_HS;
                    tx_packet_nxt = (buffer_occupancy != '0) ? TXP_DATA0 : TXP_NAK;
                    tx_start_nxt  = 1'b1;
                    d_mode_nxt    = 1'b1;
                    seen_nxt      = 1'b0;
                    hs_ack_nxt    = 1'b0;
                    ret_armed_nxt = 1'b1;
                end else if (pkt_out) begin
                    state_nxt     = RX_WAIT_DATA;
                    timer_nxt     = '0;
                    ret_armed_nxt = 1'b1;
                end
            end

            TX_DATA: begin
                if (tx_transfer_active) seen_nxt = 1'b1;
                if (tx_error) begin
                    state_nxt     = IDLE;
                    d_mode_nxt    = 1'b0;
                    tx_packet_nxt = TXP_IDLE;
                    seen_nxt      = 1'b0;
                    clear_nxt     = 1'b1;
                    set_err       = 1'b1;
                end else if (seen && !tx_transfer_active) begin
                    state_nxt     = TX_WAIT_ACK;
                    timer_nxt     = '0;
                    d_mode_nxt    = 1'b0;
                    tx_packet_nxt = TXP_IDLE;
                    seen_nxt      = 1'b0;
                end
            end

            TX_WAIT_ACK: begin
                if (pkt_ack) begin
                    state_nxt   = IDLE;
                    tx_done_nxt = 1'b1;
                    clear_nxt   = 1'b1;
                end else if (pkt_known || timeout) begin
                    state_nxt = IDLE;
                    clear_nxt = 1'b1;
                    set_err   = 1'b1;
                end else begin
                    timer_nxt = timer_inc;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            seen         <= 1'b0;
            ret_armed    <= 1'b0;
            hs_ack       <= 1'b0;
            tx_packet    <= TXP_IDLE;
            tx_start     <= 1'b0;
            d_mode       <= 1'b0;
            clear_buffer <= 1'b0;
            rx_done      <= 1'b0;
            tx_done      <= 1'b0;
            xfer_error   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            seen         <= seen_nxt;
            ret_armed    <= ret_armed_nxt;
            hs_ack       <= hs_ack_nxt;
            tx_packet    <= tx_packet_nxt;
            tx_start     <= tx_start_nxt;
            d_mode       <= d_mode_nxt;
            clear_buffer <= clear_nxt;
            rx_done      <= rx_done_nxt;
            tx_done      <= tx_done_nxt;
            // A new error outranks a simultaneous clear.
            xfer_error   <= set_err | (xfer_error & ~err_clear);
            busy         <= (state_nxt != IDLE) && (state_nxt != TX_ARMED);
        end
    end

endmodule
